// File: rtl/seq_trigger.sv
// Pattern/edge trigger sequencer: watches a registered bus for a masked match and
// issues a delayed one-cycle start pulse, with optional holdoff and re-arm.
module seq_trigger #(
    parameter int IN_BITS  = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                SEQ_CLK,
    input  logic                SEQ_RST_N,
    input  logic [IN_BITS-1:0]  SEQ_IN,
    input  logic [IN_BITS-1:0]  CONF_PATTERN,
    input  logic [IN_BITS-1:0]  CONF_MASK,
    input  logic                CONF_EDGE,
    input  logic                CONF_CONT,
    input  logic [CNT_BITS-1:0] CONF_DELAY,
    input  logic [CNT_BITS-1:0] CONF_HOLDOFF,
    input  logic                CONF_ARM,
    input  logic                CONF_ABORT,
    output logic                SEQ_EXT_START,
    output logic                BUSY,
    output logic                DONE,
    output logic [CNT_BITS-1:0] TRIG_CNT
);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, HOLDOFF} state_t;

    state_t              state_q, state_d;
    logic [IN_BITS-1:0]  s1_q, s1_d;
    logic                match_prev_q, match_prev_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic [CNT_BITS-1:0] trig_cnt_q, trig_cnt_d;
    logic                match, trig, fire;

    always_comb begin
        s1_d         = SEQ_IN;
        match        = (((s1_q ^ CONF_PATTERN) & CONF_MASK) == '0);
        match_prev_d = match;
        trig         = CONF_EDGE ? (match & ~match_prev_q) : match;

        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        done_d     = done_q;
        trig_cnt_d = trig_cnt_q;
        fire       = 1'b0;

        case (state_q)
            IDLE: begin
                if (CONF_ARM) begin
                    state_d    = ARMED;
                    done_d     = 1'b0;
                    trig_cnt_d = '0;
                end
            end
            ARMED: begin
                if (trig) begin
                    if (CONF_DELAY == '0) begin
                        fire = 1'b1;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = CONF_DELAY;
                    end
                end
            end
            DELAY: begin
                // Counter holds the remaining cycles, so the last one fires.
                if (cnt_q == CNT_BITS'(1)) fire = 1'b1;
                else                       cnt_d = cnt_q - CNT_BITS'(1);
            end
            HOLDOFF: begin
                if (cnt_q == CNT_BITS'(1)) state_d = ARMED;
                else                       cnt_d   = cnt_q - CNT_BITS'(1);
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            start_d = 1'b1;
            if (trig_cnt_q != '1) trig_cnt_d = trig_cnt_q + CNT_BITS'(1);
            if (CONF_CONT) begin
                if (CONF_HOLDOFF == '0) begin
                    state_d = ARMED;
                end else begin
                    state_d = HOLDOFF;
                    cnt_d   = CONF_HOLDOFF;
                end
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort wins over arm and over a coincident fire; status is preserved.
        if (CONF_ABORT) begin
            state_d    = IDLE;
            cnt_d      = cnt_q;
            start_d    = 1'b0;
            done_d     = done_q;
            trig_cnt_d = trig_cnt_q;
        end
    end

    always_ff @(posedge SEQ_CLK or negedge SEQ_RST_N) begin
        if (!SEQ_RST_N) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            match_prev_q <= 1'b1;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            trig_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            match_prev_q <= match_prev_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            done_q       <= done_d;
            trig_cnt_q   <= trig_cnt_d;
        end
    end

    assign SEQ_EXT_START = start_q;
    assign BUSY          = (state_q != IDLE);
    assign DONE          = done_q;
    assign TRIG_CNT      = trig_cnt_q;

endmodule

// File: doc/seq_trigger.md
SEQ_TRIGGER -- requirements
Module: seq_trigger

Interface
REQ-001 SHALL have parameter IN_BITS, default 8, which sets the width of the monitored bus.
REQ-002 SHALL have parameter CNT_BITS, default 16, which sets the width of the delay, holdoff and trigger-count fields.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 SEQ_CLK  in  1  sole clock; all logic on rising edge.
REQ-005 SEQ_RST_N  in  1  async active-low reset.
REQ-006 SEQ_IN  in  IN_BITS  monitored bus, synchronous to SEQ_CLK.
REQ-007 CONF_PATTERN  in  IN_BITS  compare value.
REQ-008 CONF_MASK  in  IN_BITS  compare enable per bit; 1 = compared.
REQ-009 CONF_EDGE  in  1  selects the match mode: 0 = level match, 1 = rising edge of match.
REQ-010 CONF_CONT  in  1  selects the run mode: 1 = re-arm after holdoff, 0 = single shot.
REQ-011 CONF_DELAY  in  CNT_BITS  cycles between match and start pulse.
REQ-012 CONF_HOLDOFF  in  CNT_BITS  dead cycles after a pulse before re-arming.
REQ-013 CONF_ARM  in  1  single-cycle arm request.
REQ-014 CONF_ABORT  in  1  single-cycle abort request.
REQ-015 SEQ_EXT_START  out  1  registered one-cycle start pulse, drives the recorder start input.
REQ-016 BUSY  out  1  high in any state other than IDLE.
REQ-017 DONE  out  1  sticky flag, set when a single-shot sequence completes, cleared by CONF_ARM.
REQ-018 TRIG_CNT  out  CNT_BITS  count of start pulses since last arm, saturating.

Function
REQ-019 SEQ_IN SHALL be registered once (s1); match = (((s1 ^ CONF_PATTERN) & CONF_MASK) == 0).
REQ-020 match_prev SHALL be updated every cycle regardless of state.
REQ-021 Trigger condition SHALL be as follows.
- CONF_EDGE=0: the condition is match.
- CONF_EDGE=1: the condition is match & ~match_prev.
REQ-022 CONF_MASK = 0 SHALL cause the following.
- Level mode: immediate trigger.
- Edge mode: no trigger ever.
REQ-023 State machine SHALL have states IDLE, ARMED, DELAY, HOLDOFF.
REQ-024 IDLE -> ARMED SHALL occur on CONF_ARM, which also clears DONE and TRIG_CNT.
REQ-025 CONF_ARM SHALL be ignored outside IDLE.
REQ-026 From ARMED on the trigger condition, the block SHALL do the following.
- Latch CONF_DELAY.
- If the latched value is 0, fire immediately.
- Otherwise go to DELAY and count down the latched value.
REQ-027 Fire SHALL do the following.
- Assert SEQ_EXT_START for exactly one cycle.
- Increment TRIG_CNT, saturating at all-ones.
- Latch CONF_HOLDOFF.
REQ-028 After fire, the next state SHALL be determined as follows.
- If CONF_CONT=1 and the latched holdoff is 0: ARMED.
- If CONF_CONT=1 and the latched holdoff is non-zero: HOLDOFF, for exactly that many cycles, then ARMED.
- If CONF_CONT=0: IDLE with DONE set.
REQ-029 Latency SHALL be as follows: SEQ_IN value sampled at edge k that satisfies the trigger while ARMED gives SEQ_EXT_START high during the cycle after edge k+1+CONF_DELAY.
REQ-030 Triggers occurring in DELAY or HOLDOFF SHALL be ignored and not queued.
REQ-031 Edge detection SHALL still track during DELAY and HOLDOFF, so a match held through HOLDOFF does not refire in edge mode.
REQ-032 CONF_ABORT SHALL force IDLE from any state within one cycle.
- No pulse is issued.
- DONE is left unchanged.
- TRIG_CNT is held.
REQ-033 CONF_ABORT and CONF_ARM asserted together SHALL resolve to abort.
REQ-034 A fire coinciding with CONF_ABORT SHALL be suppressed.
REQ-035 CONF_PATTERN, CONF_MASK and CONF_EDGE SHALL be used live; CONF_DELAY and CONF_HOLDOFF only at latch points.
REQ-036 Counters SHALL be CNT_BITS wide with no wrap; a delay of all-ones SHALL be honoured exactly.

Reset
REQ-037 Asserting SEQ_RST_N low SHALL immediately produce the following.
- State IDLE.
- s1 = 0.
- match_prev = 1.
- SEQ_EXT_START, BUSY, DONE and TRIG_CNT all 0.
REQ-038 Reset mid-DELAY or mid-HOLDOFF SHALL discard the pending pulse.
REQ-039 The block SHALL NOT trigger in the first cycle after reset release.

Verification
REQ-040 Level, delay 0: MASK=0xFF, PATTERN=0x5A, CONT=0, arm, then SEQ_IN=0x5A at edge k -> one pulse after edge k+1, DONE=1, TRIG_CNT=1, BUSY=0.
REQ-041 Delay and mask: MASK=0x0F, PATTERN=0x03, DELAY=5, SEQ_IN=0xA3 -> pulse exactly 6 cycles after the sampling edge; SEQ_IN=0xA2 -> no pulse.
REQ-042 Continuous edge mode: EDGE=1, CONT=1, HOLDOFF=3, pattern matched on cycles 10-20 then 30 -> exactly two pulses (cycles 10 and 30), TRIG_CNT=2, BUSY stays 1.
REQ-043 Abort: DELAY=100, abort 50 cycles after match -> no pulse, IDLE, DONE=0; simultaneous ARM+ABORT in IDLE -> stays IDLE.
REQ-044 Reset: SEQ_RST_N low during HOLDOFF -> all outputs 0 asynchronously; no pulse after release.
REQ-045 Saturation: CNT_BITS=4, CONT=1, MASK=0, 20 triggers -> TRIG_CNT holds 15.
